// File: rtl/bus_initiator.sv
// Requester-side master for the sdsubus operand/result bus.
// Queues operand pairs in a small FIFO and runs one bus transaction at a time, with a timeout.
module bus_initiator #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [15:0] cmd_a,
   input  logic [15:0] cmd_b,
   output logic        cmd_ready,
   output logic [15:0] A,
   output logic [15:0] B,
   output logic        valid_signal,
   input  logic        ready_signal,
   input  logic [31:0] result,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        busy,
   output logic [15:0] txn_count,
   output logic [7:0]  err_count
);
   localparam int PW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
   localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [TW-1:0] TMR_MAX  = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMR_ONE  = TW'(1);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_REQ  = 1'b1;

   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [0:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0]   a_q, a_d, b_q, b_d;
   logic          valid_q, valid_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;
   logic [15:0]   txn_count_q, txn_count_d;
   logic [7:0]    err_count_q, err_count_d;

   logic push, pop;
   logic [31:0] head;

   // Ready depends only on the registered count, so a pop never frees a slot in the same cycle.
   assign cmd_ready = (count_q != CNT_FULL);
   assign push      = cmd_valid & cmd_ready;
   assign pop       = (state_q == ST_IDLE) && (count_q != '0);
   assign head      = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {cmd_a, cmd_b};
      end
   end

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      state_d     = state_q;
      timer_d     = timer_q;
      a_d         = a_q;
      b_d         = b_q;
      valid_d     = valid_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      txn_count_d = txn_count_q;
      err_count_d = err_count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push && !pop) begin
         count_d = count_q + CNT_ONE;
      end else if (!push && pop) begin
         count_d = count_q - CNT_ONE;
      end

      case (state_q)
         ST_IDLE: begin
            if (pop) begin
               a_d     = head[31:16];
               b_d     = head[15:0];
               valid_d = 1'b1;
               timer_d = '0;
               state_d = ST_REQ;
            end
         end
         default: begin
            if (ready_signal) begin
               rsp_data_d  = result;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               txn_count_d = txn_count_q + 16'd1;
               valid_d     = 1'b0;
               state_d     = ST_IDLE;
            end else if (timer_q == TMR_MAX) begin
               rsp_data_d  = '0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               if (err_count_q != 8'hFF) begin
                  err_count_d = err_count_q + 8'd1;
               end
               valid_d     = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               timer_d = timer_q + TMR_ONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         a_q         <= '0;
         b_q         <= '0;
         valid_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         txn_count_q <= '0;
         err_count_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         state_q     <= state_d;
         timer_q     <= timer_d;
         a_q         <= a_d;
         b_q         <= b_d;
         valid_q     <= valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         txn_count_q <= txn_count_d;
         err_count_q <= err_count_d;
      end
   end

   assign A            = a_q;
   assign B            = b_q;
   assign valid_signal = valid_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_data     = rsp_data_q;
   assign rsp_err      = rsp_err_q;
   assign txn_count    = txn_count_q;
   assign err_count    = err_count_q;
   assign busy         = (state_q != ST_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bus_initiator;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [15:0] cmd_a = '0, cmd_b = '0;
   logic        cmd_ready;
   logic [15:0] A, B;
   logic        valid_signal;
   logic        ready_signal = 1'b0;
   logic [31:0] result = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        busy;
   logic [15:0] txn_count;
   logic [7:0]  err_count;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   bus_initiator #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ready(cmd_ready),
      .A(A), .B(B), .valid_signal(valid_signal),
      .ready_signal(ready_signal), .result(result),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .busy(busy), .txn_count(txn_count), .err_count(err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pending requests as a queue, one in-flight request with its wait age.
   logic [31:0] m_q[$];
   bit          m_inflight = 0;
   int          m_age = 0;
   logic [15:0] m_a = '0, m_b = '0;
   bit          m_rv = 0;
   logic [31:0] m_rd = '0;
   bit          m_re = 0;
   logic [15:0] m_txn = '0;
   int          m_err = 0;
   int          m_sz;
   logic [31:0] m_op;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_q.delete();
         m_inflight = 0; m_age = 0; m_a = '0; m_b = '0;
         m_rv = 0; m_rd = '0; m_re = 0; m_txn = '0; m_err = 0;
      end else begin
         m_sz = m_q.size();
         m_rv = 0;
         if (m_inflight) begin
            if (ready_signal) begin
               m_rv = 1; m_rd = result; m_re = 0; m_txn = m_txn + 16'd1; m_inflight = 0;
            end else if (m_age == TIMEOUT - 1) begin
               m_rv = 1; m_rd = '0; m_re = 1; m_inflight = 0;
               if (m_err < 255) m_err++;
            end else begin
               m_age++;
            end
         end else if (m_sz > 0) begin
            m_op = m_q.pop_front();
            m_a = m_op[31:16]; m_b = m_op[15:0];
            m_inflight = 1; m_age = 0;
         end
         if (cmd_valid && m_sz < DEPTH) m_q.push_back({cmd_a, cmd_b});
      end
   end

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("cmd_ready", cmd_ready, (m_q.size() < DEPTH));
         chk("valid_signal", valid_signal, m_inflight);
         chk("A", A, m_a);
         chk("B", B, m_b);
         chk("rsp_valid", rsp_valid, m_rv);
         chk("rsp_data", rsp_data, m_rd);
         chk("rsp_err", rsp_err, m_re);
         chk("busy", busy, (m_inflight || m_q.size() > 0));
         chk("txn_count", txn_count, m_txn);
         chk("err_count", err_count, m_err);
         if (rsp_valid)
            $display("[TB] rsp data=%08h err=%0d txn=%0d errs=%0d", rsp_data, rsp_err, txn_count, err_count);
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int acc, got, hi, rp;
   bit seen;
   logic [15:0] saved_txn;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_valid", valid_signal, 0);
      chk("rst_busy", busy, 0);
      chk("rst_txn", txn_count, 0);
      chk("rst_A", A, 0);

      // single request
      cmd_valid = 1; cmd_a = 25; cmd_b = 25;
      @(negedge clk); cmd_valid = 0;
      @(negedge clk);
      chk("single_valid", valid_signal, 1);
      chk("single_A", A, 25);
      ready_signal = 1; result = 32'd625;
      @(negedge clk);
      chk("single_rsp_valid", rsp_valid, 1);
      chk("single_rsp_data", rsp_data, 625);
      chk("single_rsp_err", rsp_err, 0);
      chk("single_txn", txn_count, 1);
      chk("single_valid_low", valid_signal, 0);
      ready_signal = 0;
      @(negedge clk);
      chk("single_pulse_end", rsp_valid, 0);
      chk("single_gap", valid_signal, 0);

      // FIFO fill with stalled bus
      acc = 0;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         cmd_valid = 1; cmd_a = 16'(i); cmd_b = 16'(i);
         if (cmd_ready) acc++;
      end
      @(negedge clk);
      cmd_valid = 0;
      chk("fill_accepted", acc, 5);
      chk("fill_full", cmd_ready, 0);
      ready_signal = 1;
      got = 0;
      for (int k = 0; k < 60 && got < 5; k++) begin
         if (rsp_valid) begin
            chk("fill_order", rsp_data, (got + 1) * (got + 1));
            got++;
         end
         result = {16'd0, A} * {16'd0, B};
         if (got < 5) @(negedge clk);
      end
      chk("fill_got", got, 5);
      ready_signal = 0;

      // timeout
      @(negedge clk); cmd_valid = 1; cmd_a = 3; cmd_b = 4;
      @(negedge clk); cmd_a = 5; cmd_b = 6;
      @(negedge clk); cmd_valid = 0;
      hi = 0; seen = 0;
      for (int k = 0; k < 40; k++) begin
         if (rsp_valid) begin seen = 1; break; end
         if (valid_signal) hi++;
         @(negedge clk);
      end
      chk("to_seen", seen, 1);
      chk("to_valid_cycles", hi, 16);
      chk("to_err", rsp_err, 1);
      chk("to_data", rsp_data, 0);
      chk("to_errcnt", err_count, 1);
      chk("to_idle_gap", valid_signal, 0);
      @(negedge clk);
      chk("to_next_issue", valid_signal, 1);
      chk("to_next_A", A, 5);
      ready_signal = 1; result = 32'd30;
      @(negedge clk);
      chk("to_next_rsp", rsp_valid, 1);
      chk("to_next_data", rsp_data, 30);
      ready_signal = 0;

      // stray ready in IDLE
      @(negedge clk);
      saved_txn = txn_count;
      ready_signal = 1; result = 32'hDEAD;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("stray_no_rsp", rsp_valid, 0);
         chk("stray_txn", txn_count, saved_txn);
         chk("stray_err", err_count, 1);
      end
      ready_signal = 0;

      // reset mid-transaction with two queued
      @(negedge clk); cmd_valid = 1; cmd_a = 7; cmd_b = 7;
      @(negedge clk); cmd_a = 8; cmd_b = 8;
      @(negedge clk); cmd_a = 9; cmd_b = 9;
      @(negedge clk); cmd_valid = 0;
      chk("rm_pre_valid", valid_signal, 1);
      chk("rm_pre_busy", busy, 1);
      #1 rst = 1'b1;
      #1;
      chk("rm_valid_drop", valid_signal, 0);
      chk("rm_cmd_ready", cmd_ready, 1);
      chk("rm_busy", busy, 0);
      chk("rm_rsp", rsp_valid, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      ready_signal = 1; result = 32'hDEAD;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("rm_no_rsp", rsp_valid, 0);
         chk("rm_no_valid", valid_signal, 0);
         chk("rm_txn", txn_count, 0);
      end
      ready_signal = 0;

      // randomized traffic
      for (int k = 0; k < 2500; k++) begin
         @(negedge clk);
         rp = (k < 800) ? 5 : (k < 1600) ? 35 : 90;
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_a = 16'($urandom);
         cmd_b = 16'($urandom);
         ready_signal = ($urandom_range(0, 99) < rp);
         result = valid_signal ? ({16'd0, A} * {16'd0, B}) : $urandom;
      end

      // error counter saturation
      cmd_valid = 1; ready_signal = 0;
      seen = 0;
      for (int k = 0; k < 6000; k++) begin
         @(negedge clk);
         cmd_a = 16'($urandom); cmd_b = 16'($urandom);
         if (err_count == 8'hFF) begin seen = 1; break; end
      end
      chk("sat_reached", seen, 1);
      repeat (60) @(negedge clk);
      chk("sat_hold", err_count, 255);
      cmd_valid = 0;
      repeat (20) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
